// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying pc/pc+8/payload/delay-slot/exception; flush redirects to flush_pc.
// Latency: one cycle from input transfer to out_valid; reset and flush both take effect on the next edge.
// Backpressure: PIPE_SKID_EN gives a head+skid pair with registered in_ready, otherwise a single entry with pass-through in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int EXC_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc8,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bd,
    output logic [EXC_W-1:0]  out_exc,
    output logic [1:0]        occupancy,
    output logic              exc_pending
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(8);

    logic              head_vld_q, head_vld_d;
    logic [PC_W-1:0]   head_pc_q, head_pc_d;
    logic [PC_W-1:0]   head_pc8_q, head_pc8_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic              head_bd_q, head_bd_d;
    logic [EXC_W-1:0]  head_exc_q, head_exc_d;
    logic              exc_pending_q, exc_pending_d;

    logic              in_fire;
    logic              out_fire;
    logic [PC_W-1:0]   in_pc8;
    logic [PC_W-1:0]   flush_pc8;

    // pc+8 is formed once at load so the output never carries an adder
    assign in_pc8    = in_pc + PC_STEP;
    assign flush_pc8 = flush_pc + PC_STEP;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = head_vld_q & out_ready;

    assign out_valid   = head_vld_q;
    assign out_pc      = head_pc_q;
    assign out_pc8     = head_pc8_q;
    assign out_data    = head_data_q;
    assign out_bd      = head_bd_q;
    assign out_exc     = head_exc_q;
    assign exc_pending = exc_pending_q;

`ifdef PIPE_SKID_EN
    logic              skid_vld_q, skid_vld_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [PC_W-1:0]   skid_pc8_q, skid_pc8_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_bd_q, skid_bd_d;
    logic [EXC_W-1:0]  skid_exc_q, skid_exc_d;
    logic              in_ready_q, in_ready_d;

    assign in_ready  = in_ready_q;
    assign occupancy = {1'b0, head_vld_q} + {1'b0, skid_vld_q};

    always_comb begin
        head_vld_d    = head_vld_q;
        head_pc_d     = head_pc_q;
        head_pc8_d    = head_pc8_q;
        head_data_d   = head_data_q;
        head_bd_d     = head_bd_q;
        head_exc_d    = head_exc_q;
        skid_vld_d    = skid_vld_q;
        skid_pc_d     = skid_pc_q;
        skid_pc8_d    = skid_pc8_q;
        skid_data_d   = skid_data_q;
        skid_bd_d     = skid_bd_q;
        skid_exc_d    = skid_exc_q;
        in_ready_d    = in_ready_q;
        exc_pending_d = exc_pending_q;

        if (reset) begin
            head_vld_d  = 1'b0;
            head_pc_d   = '0;
            head_pc8_d  = '0;
            head_data_d = '0;
            head_bd_d   = 1'b0;
            head_exc_d  = '0;
            skid_vld_d  = 1'b0;
            skid_pc_d   = '0;
            skid_pc8_d  = '0;
            skid_data_d = '0;
            skid_bd_d   = 1'b0;
            skid_exc_d  = '0;
            in_ready_d  = 1'b1;
        end else if (flush) begin
            head_vld_d  = 1'b0;
            head_pc_d   = flush_pc;
            head_pc8_d  = flush_pc8;
            head_data_d = '0;
            head_bd_d   = 1'b0;
            head_exc_d  = '0;
            skid_vld_d  = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            if (out_fire) begin
                if (skid_vld_q) begin
                    head_pc_d   = skid_pc_q;
                    head_pc8_d  = skid_pc8_q;
                    head_data_d = skid_data_q;
                    head_bd_d   = skid_bd_q;
                    head_exc_d  = skid_exc_q;
                    skid_vld_d  = 1'b0;
                end else begin
                    head_vld_d = 1'b0;
                end
            end
            if (in_fire) begin
                // head takes the input only if it ends this cycle empty
                if (!head_vld_q || (out_fire && !skid_vld_q)) begin
                    head_vld_d  = 1'b1;
                    head_pc_d   = in_pc;
                    head_pc8_d  = in_pc8;
                    head_data_d = in_data;
                    head_bd_d   = in_bd;
                    head_exc_d  = in_exc;
                end else begin
                    skid_vld_d  = 1'b1;
                    skid_pc_d   = in_pc;
                    skid_pc8_d  = in_pc8;
                    skid_data_d = in_data;
                    skid_bd_d   = in_bd;
                    skid_exc_d  = in_exc;
                end
            end
            in_ready_d = !skid_vld_d;
        end
        exc_pending_d = (head_vld_d && (head_exc_d != '0)) ||
                        (skid_vld_d && (skid_exc_d != '0));
    end

    always_ff @(posedge clk) begin
        skid_vld_q  <= skid_vld_d;
        skid_pc_q   <= skid_pc_d;
        skid_pc8_q  <= skid_pc8_d;
        skid_data_q <= skid_data_d;
        skid_bd_q   <= skid_bd_d;
        skid_exc_q  <= skid_exc_d;
        in_ready_q  <= in_ready_d;
    end
`else
    // a full head can still accept when it drains in the same cycle
    assign in_ready  = !head_vld_q | out_ready;
    assign occupancy = {1'b0, head_vld_q};

    always_comb begin
        head_vld_d    = head_vld_q;
        head_pc_d     = head_pc_q;
        head_pc8_d    = head_pc8_q;
        head_data_d   = head_data_q;
        head_bd_d     = head_bd_q;
        head_exc_d    = head_exc_q;
        exc_pending_d = exc_pending_q;

        if (reset) begin
            head_vld_d  = 1'b0;
            head_pc_d   = '0;
            head_pc8_d  = '0;
            head_data_d = '0;
            head_bd_d   = 1'b0;
            head_exc_d  = '0;
        end else if (flush) begin
            head_vld_d  = 1'b0;
            head_pc_d   = flush_pc;
            head_pc8_d  = flush_pc8;
            head_data_d = '0;
            head_bd_d   = 1'b0;
            head_exc_d  = '0;
        end else if (in_fire) begin
            head_vld_d  = 1'b1;
            head_pc_d   = in_pc;
            head_pc8_d  = in_pc8;
            head_data_d = in_data;
            head_bd_d   = in_bd;
            head_exc_d  = in_exc;
        end else if (out_fire) begin
            head_vld_d = 1'b0;
        end
        exc_pending_d = head_vld_d && (head_exc_d != '0);
    end
`endif

    always_ff @(posedge clk) begin
        head_vld_q    <= head_vld_d;
        head_pc_q     <= head_pc_d;
        head_pc8_q    <= head_pc8_d;
        head_data_q   <= head_data_d;
        head_bd_q     <= head_bd_d;
        head_exc_q    <= head_exc_d;
        exc_pending_q <= exc_pending_d;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle, plus literal checkpoints.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [31:0] data;
        logic        bd;
        logic [4:0]  exc;
    } bundle_t;

`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_data = '0;
    logic        in_bd = 1'b0;
    logic [4:0]  in_exc = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_pc8, out_data;
    logic        out_bd;
    logic [4:0]  out_exc;
    logic [1:0]  occupancy;
    logic        exc_pending;

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    bundle_t q[$];
    bundle_t last = '0;

    pipe_stage_reg #(.DATA_W(32), .PC_W(32), .EXC_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_data(in_data), .in_bd(in_bd), .in_exc(in_exc),
        .flush(flush), .flush_pc(flush_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc8(out_pc8), .out_data(out_data),
        .out_bd(out_bd), .out_exc(out_exc),
        .occupancy(occupancy), .exc_pending(exc_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_in_ready();
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    // Reference: a bounded FIFO of bundles; empty outputs show the last bundle seen.
    always @(posedge clk) begin
        logic rdy;
        bundle_t b;
        rdy = model_in_ready();
        if (reset) begin
            q.delete();
            last = '0;
        end else if (flush) begin
            q.delete();
            last = '0;
            last.pc = flush_pc;
            last.pc8 = flush_pc + 32'd8;
        end else begin
            if (q.size() > 0 && out_ready) last = q.pop_front();
            if (in_valid && rdy) begin
                b.pc = in_pc; b.pc8 = in_pc + 32'd8; b.data = in_data;
                b.bd = in_bd; b.exc = in_exc;
                q.push_back(b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bundle_t h;
            logic pend;
            h = (q.size() > 0) ? q[0] : last;
            pend = 1'b0;
            foreach (q[i]) if (q[i].exc != 0) pend = 1'b1;
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("in_ready", 64'(in_ready), 64'(model_in_ready()));
            check("out_pc", 64'(out_pc), 64'(h.pc));
            check("out_pc8", 64'(out_pc8), 64'(h.pc8));
            check("out_data", 64'(out_data), 64'(h.data));
            check("out_bd", 64'(out_bd), 64'(h.bd));
            check("out_exc", 64'(out_exc), 64'(h.exc));
            check("occupancy", 64'(occupancy), 64'(q.size()));
            check("exc_pending", 64'(exc_pending), 64'(pend));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] d,
                         input logic bd, input logic [4:0] e);
        in_valid = v; in_pc = pc; in_data = d; in_bd = bd; in_exc = e;
    endtask

    initial begin
        logic [15:0] vpat;
        logic [10:0] rpat;
        vpat = 16'b1011_0111_1100_1101;
        rpat = 11'b101_1001_1101;

        step(); step();
        chk_en = 1'b1;
        reset = 1'b0;
        step();
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_pc8", 64'(out_pc8), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);

        // single accept with downstream ready
        step();
        out_ready = 1'b1;
        drive(1'b1, 32'h3000, 32'h2401_0001, 1'b0, 5'd0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        check("acc_out_valid", 64'(out_valid), 64'd1);
        check("acc_out_pc", 64'(out_pc), 64'h3000);
        check("acc_out_pc8", 64'(out_pc8), 64'h3008);
        check("acc_occupancy", 64'(occupancy), 64'd1);
        step(); step();

        // stalled downstream, two offers, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'h3000, 32'h1111_0000, 1'b0, 5'd0);
        step();
        drive(1'b1, 32'h3004, 32'h2222_0000, 1'b1, 5'd0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        check("stall_occupancy", 64'(occupancy), 64'(CAP));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_first_pc", 64'(out_pc), 64'h3000);
        step();
        @(negedge clk);
        if (CAP == 2) begin
            check("drain_second_pc", 64'(out_pc), 64'h3004);
            check("drain_second_vld", 64'(out_valid), 64'd1);
        end else begin
            check("drain_empty_vld", 64'(out_valid), 64'd0);
            check("drain_retain_pc", 64'(out_pc), 64'h3000);
        end
        step(); step();

        // mixed streaming traffic
        for (int i = 0; i < 64; i++) begin
            out_ready = rpat[i % 11];
            drive(vpat[i % 16], 32'h1000 + 32'(4 * i), 32'hA500_0000 ^ 32'(i),
                  1'(i % 2), (i % 7 == 3) ? 5'd2 : 5'd0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        out_ready = 1'b0;
        step();

        // flush with a same-cycle input
        drive(1'b1, 32'h5000, 32'hDEAD_BEEF, 1'b1, 5'd3);
        step();
        flush = 1'b1;
        flush_pc = 32'h4180;
        drive(1'b1, 32'h5004, 32'hCAFE_F00D, 1'b1, 5'd3);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_pc", 64'(out_pc), 64'h4180);
        check("flush_out_pc8", 64'(out_pc8), 64'h4188);
        check("flush_out_data", 64'(out_data), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        step(); step();
        @(negedge clk);
        check("flush_not_delivered", 64'(out_valid), 64'd0);

        // pc wrap and exception tracking
        out_ready = 1'b0;
        drive(1'b1, 32'hFFFF_FFFC, 32'h0000_000C, 1'b0, 5'd4);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        check("wrap_out_pc8", 64'(out_pc8), 64'h4);
        check("exc_pending_set", 64'(exc_pending), 64'd1);
        step(); step();
        @(negedge clk);
        check("exc_pending_held", 64'(exc_pending), 64'd1);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("exc_pending_clear", 64'(exc_pending), 64'd0);
        check("exc_out_exc_retained", 64'(out_exc), 64'd4);

        // reset beats flush with storage full
        out_ready = 1'b0;
        drive(1'b1, 32'h6000, 32'h0000_0006, 1'b1, 5'd1);
        step();
        drive(1'b1, 32'h6004, 32'h0000_0007, 1'b0, 5'd1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        check("pre_rst_occupancy", 64'(occupancy), 64'(CAP));
        step();
        reset = 1'b1;
        flush = 1'b1;
        flush_pc = 32'h4180;
        step();
        reset = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("rf_out_valid", 64'(out_valid), 64'd0);
        check("rf_out_pc", 64'(out_pc), 64'd0);
        check("rf_out_pc8", 64'(out_pc8), 64'd0);
        check("rf_occupancy", 64'(occupancy), 64'd0);
        check("rf_in_ready", 64'(in_ready), 64'd1);
        check("rf_exc_pending", 64'(exc_pending), 64'd0);
        step(); step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
